// File: rtl/adder_32bit_seq.sv
// Sequential 32-bit adder: one 4-bit carry-lookahead slice is reused over
// eight RUN cycles, least-significant nibble first.

module adder_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       c3,
    output logic       co
);
    logic [3:0] g, p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        s    = p ^ c[3:0];
        c3   = c[3];
        co   = c[4];
    end
endmodule

module adder_32bit_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic        busy,
    output logic        done,
    output logic [31:0] Result,
    output logic        Cout,
    output logic        Ovf
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [31:0] a_q, b_q, sum_q;
    logic        carry;
    logic [2:0]  cnt;
    logic [4:0]  lsb;
    logic [3:0]  na, nb, ns;
    logic        nc3, nco;

    assign lsb = {cnt, 2'b00};
    assign na  = a_q[lsb +: 4];
    assign nb  = b_q[lsb +: 4];

    adder_cla4 u_cla (
        .a  (na),
        .b  (nb),
        .ci (carry),
        .s  (ns),
        .c3 (nc3),
        .co (nco)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            Result <= '0;
            Cout   <= 1'b0;
            Ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        carry <= Cin;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum_q[lsb +: 4] <= ns;
                    carry           <= nco;
                    cnt             <= cnt + 3'd1;
                    // Last nibble: publish straight from the slice so the top
                    // nibble and the bit-31 carries land in the same edge.
                    if (cnt == 3'd7) begin
                        Result <= {ns, sum_q[27:0]};
                        Cout   <= nco;
                        Ovf    <= nc3 ^ nco;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_adder_32bit_seq.sv
// Randomized self-checking bench for adder_32bit_seq against a plain
// arithmetic reference of A+B+Cin.

module tb_adder_32bit_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic        Cin = 1'b0;
    logic        busy, done, Cout, Ovf;
    logic [31:0] Result;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [31:0] exp_res = '0;
    logic        exp_co  = 1'b0;
    logic        exp_ov  = 1'b0;

    adder_32bit_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A      (A),
        .B      (B),
        .Cin    (Cin),
        .busy   (busy),
        .done   (done),
        .Result (Result),
        .Cout   (Cout),
        .Ovf    (Ovf)
    );

    always #5 clk = ~clk;

    // {Ovf, Cout, Result}
    function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic cin);
        logic [32:0] s;
        logic        ov;
        s  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        ov = (a[31] == b[31]) && (s[31] != a[31]);
        return {ov, s};
    endfunction

    // One full operation from IDLE; inputs are scrambled during RUN and an
    // optional start pulse lands in RUN cycle 3.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input bit pulse3, input string name);
        logic [33:0] r;
        int          bad_run;
        int          bad_hold;
        r        = ref_add(a, b, cin);
        bad_run  = 0;
        bad_hold = 0;
        @(negedge clk);
        start = 1'b1; A = a; B = b; Cin = cin;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = (pulse3 && k == 3);
            A = $urandom; B = $urandom; Cin = 1'($urandom_range(0, 1));
            if (busy !== 1'b1 || done !== 1'b0) bad_run++;
            if (Result !== exp_res || Cout !== exp_co || Ovf !== exp_ov) bad_hold++;
        end
        chk_cnt++;
        if (bad_run == 0) pass_cnt++;
        else $display("FAIL %s busy/done during RUN: %0d bad cycles, required 0", name, bad_run);
        chk_cnt++;
        if (bad_hold == 0) pass_cnt++;
        else $display("FAIL %s outputs held during RUN: %0d bad cycles, required 0", name, bad_hold);
        @(negedge clk);
        start = 1'b0;
        chk_cnt++;
        if (done !== 1'b1 || busy !== 1'b0) $display("FAIL %s done pulse: done=%b busy=%b, required done=1 busy=0", name, done, busy);
        else pass_cnt++;
        chk_cnt++;
        if ({Ovf, Cout, Result} !== r)
            $display("FAIL %s result: Ovf=%b Cout=%b Result=%h, required Ovf=%b Cout=%b Result=%h",
                     name, Ovf, Cout, Result, r[33], r[32], r[31:0]);
        else pass_cnt++;
        exp_res = r[31:0]; exp_co = r[32]; exp_ov = r[33];
        @(negedge clk);
        chk_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || Result !== exp_res)
            $display("FAIL %s return to idle: done=%b busy=%b Result=%h, required 0 0 %h", name, done, busy, Result, exp_res);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({busy, done, Cout, Ovf} !== 4'b0 || Result !== 32'd0)
            $display("FAIL reset state: busy=%b done=%b Cout=%b Ovf=%b Result=%h, required all 0", busy, done, Cout, Ovf, Result);
        else pass_cnt++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL idle after reset: busy=%b done=%b, required 0 0", busy, done);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        do_op(32'h0000_8001, 32'h0000_003F, 1'b0, 1'b0, "basic");
        do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "ripple");
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "pos_ovf");
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "neg_ovf");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, "all_ones");
    endtask

    task automatic test_ignore_start();
        do_op(32'd1, 32'd2, 1'b0, 1'b1, "start_in_run");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
    endtask

    task automatic test_abort();
        int stray;
        stray = 0;
        @(negedge clk);
        start = 1'b1; A = $urandom | 32'h1; B = $urandom; Cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk_cnt++;
        if ({busy, done, Cout, Ovf} !== 4'b0 || Result !== 32'd0)
            $display("FAIL async abort: busy=%b done=%b Cout=%b Ovf=%b Result=%h, required all 0", busy, done, Cout, Ovf, Result);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        exp_res = '0; exp_co = 1'b0; exp_ov = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || Result !== 32'd0) stray++;
        end
        chk_cnt++;
        if (stray != 0) $display("FAIL no done after abort: %0d bad cycles, required 0", stray);
        else pass_cnt++;
        do_op(32'd5, 32'd6, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_back_to_back();
        int bad_ctl, bad_res, dones;
        bad_ctl = 0; bad_res = 0; dones = 0;
        @(negedge clk);
        start = 1'b1; A = 32'd1; B = 32'd1; Cin = 1'b0;
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk);
            if (done !== (k % 9 == 0) || busy !== (k % 9 != 0)) bad_ctl++;
            if (done === 1'b1) begin
                dones++;
                if (Result !== 32'd2 || Cout !== 1'b0 || Ovf !== 1'b0) bad_res++;
            end
            if (k == 27) start = 1'b0;
        end
        exp_res = 32'd2; exp_co = 1'b0; exp_ov = 1'b0;
        chk_cnt++;
        if (bad_ctl != 0) $display("FAIL back_to_back cadence: %0d bad cycles, required 0", bad_ctl);
        else pass_cnt++;
        chk_cnt++;
        if (bad_res != 0 || dones != 3) $display("FAIL back_to_back results: %0d bad of %0d dones, required 0 of 3", bad_res, dones);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL back_to_back stop: busy=%b done=%b, required 0 0", busy, done);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_random();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
